// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit: shift-add multiply, restoring divide, HI/LO held until next op.
// Latency WIDTH+2 edges from accepted start to done; start is ignored while busy (no queueing).
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       func,
  input  logic [WIDTH-1:0] dataa,
  input  logic [WIDTH-1:0] datab,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             overflow
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, PREP, ITER, FIX} state_t;

  state_t state, state_nxt;

  logic [CW-1:0]    cnt;
  logic [1:0]       func_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic [WIDTH:0]   acc;
  logic [WIDTH-1:0] qr;
  logic [WIDTH-1:0] mag_b;
  logic             neg_res, neg_rem;

  logic is_div, is_signed;
  assign is_div    = func_q[1];
  assign is_signed = ~func_q[0];

  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = PREP;
      PREP:    state_nxt = ITER;
      ITER:    if (cnt == '0) state_nxt = FIX;
      FIX:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // One iteration step: acc is the running upper half (multiply) or partial remainder (divide).
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH+1:0] div_trial;
  logic [WIDTH:0]   acc_nxt;
  logic [WIDTH-1:0] qr_nxt;

  always_comb begin
    mul_sum   = acc + (qr[0] ? {1'b0, mag_b} : '0);
    div_shift = {acc[WIDTH-1:0], qr[WIDTH-1]};
    div_trial = {1'b0, div_shift} - {2'b00, mag_b};
    acc_nxt   = acc;
    qr_nxt    = qr;
    if (is_div) begin
      if (!div_trial[WIDTH+1]) begin
        acc_nxt = div_trial[WIDTH:0];
        qr_nxt  = {qr[WIDTH-2:0], 1'b1};
      end else begin
        acc_nxt = div_shift;
        qr_nxt  = {qr[WIDTH-2:0], 1'b0};
      end
    end else begin
      acc_nxt = {1'b0, mul_sum[WIDTH:1]};
      qr_nxt  = {mul_sum[0], qr[WIDTH-1:1]};
    end
  end

  logic [2*WIDTH-1:0] prod, prod_fix;
  logic [WIDTH-1:0]   q_fix, r_fix;

  always_comb begin
    prod     = {acc[WIDTH-1:0], qr};
    prod_fix = neg_res ? (~prod + 1'b1) : prod;
    q_fix    = neg_res ? (~qr + 1'b1) : qr;
    r_fix    = neg_rem ? (~acc[WIDTH-1:0] + 1'b1) : acc[WIDTH-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= '0;
      func_q   <= '0;
      a_q      <= '0;
      b_q      <= '0;
      acc      <= '0;
      qr       <= '0;
      mag_b    <= '0;
      neg_res  <= 1'b0;
      neg_rem  <= 1'b0;
      done     <= 1'b0;
      hi       <= '0;
      lo       <= '0;
      overflow <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            func_q <= func;
            a_q    <= dataa;
            b_q    <= datab;
          end
        end
        PREP: begin
          neg_res <= is_signed & (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
          neg_rem <= is_signed & a_q[WIDTH-1];
          qr      <= (is_signed && a_q[WIDTH-1]) ? (~a_q + 1'b1) : a_q;
          mag_b   <= (is_signed && b_q[WIDTH-1]) ? (~b_q + 1'b1) : b_q;
          acc     <= '0;
          cnt     <= CW'(WIDTH - 1);
        end
        ITER: begin
          acc <= acc_nxt;
          qr  <= qr_nxt;
          cnt <= cnt - 1'b1;
        end
        FIX: begin
          done <= 1'b1;
          if (!is_div) begin
            hi       <= prod_fix[2*WIDTH-1:WIDTH];
            lo       <= prod_fix[WIDTH-1:0];
            overflow <= 1'b0;
          end else if (b_q == '0) begin
            // Divide-by-zero reports the raw dividend, not the iteration residue.
            hi       <= a_q;
            lo       <= '1;
            overflow <= 1'b1;
          end else begin
            hi       <= r_fix;
            lo       <= q_fix;
            overflow <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed vector table plus handshake, back-to-back and mid-op reset sequences for muldiv_unit.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  func;
  logic [31:0] dataa, datab;
  logic        busy, done, overflow;
  logic [31:0] hi, lo;

  int checks = 0;
  int errors = 0;

  logic [31:0] prev_hi = 32'h0;
  logic [31:0] prev_lo = 32'h0;

  muldiv_unit #(.WIDTH(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .func     (func),
    .dataa    (dataa),
    .datab    (datab),
    .busy     (busy),
    .done     (done),
    .hi       (hi),
    .lo       (lo),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] e_hi;
    logic [31:0] e_lo;
    logic        e_ovf;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Call away from a clock edge; start is sampled at the next rising edge.
  task automatic issue(input logic [1:0] f, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1;
    func  = f;
    dataa = a;
    datab = b;
  endtask

  // Drops start after acceptance, scrambles operands, counts edges until done.
  task automatic wait_done(output int lat, output int bad);
    @(posedge clk);
    #1;
    start = 1'b0;
    dataa = ~dataa;
    datab = ~datab;
    func  = ~func;
    lat   = 0;
    bad   = 0;
    while (!done && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
      if (!done && (busy !== 1'b1 || hi !== prev_hi || lo !== prev_lo)) bad++;
    end
  endtask

  task automatic run_vec(input string tag, input vec_t v);
    int lat, bad;
    @(negedge clk);
    issue(v.f, v.a, v.b);
    wait_done(lat, bad);
    check({tag, "_lat"}, lat, 34);
    check({tag, "_hold"}, bad, 0);
    check({tag, "_busy"}, {31'b0, busy}, 32'h0);
    check({tag, "_hi"}, hi, v.e_hi);
    check({tag, "_lo"}, lo, v.e_lo);
    check({tag, "_ovf"}, {31'b0, overflow}, {31'b0, v.e_ovf});
    prev_hi = v.e_hi;
    prev_lo = v.e_lo;
  endtask

  initial begin
    int lat, bad, dones;

    vecs[0] = '{2'b00, 32'hFFFF_FFFD, 32'h0000_0005, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0};
    vecs[1] = '{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0};
    vecs[2] = '{2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0};
    vecs[3] = '{2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0};
    vecs[4] = '{2'b11, 32'd100,       32'd7,         32'h0000_0002, 32'h0000_000E, 1'b0};
    vecs[5] = '{2'b11, 32'd5,         32'd0,         32'h0000_0005, 32'hFFFF_FFFF, 1'b1};
    vecs[6] = '{2'b00, 32'd7,         32'd6,         32'h0000_0000, 32'h0000_002A, 1'b0};
    vecs[7] = '{2'b10, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0};
    vecs[8] = '{2'b10, 32'hFFFF_FFF8, 32'h0000_0000, 32'hFFFF_FFF8, 32'hFFFF_FFFF, 1'b1};
    vecs[9] = '{2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0};

    rst = 1'b1; start = 1'b0; func = 2'b00; dataa = '0; datab = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", {31'b0, busy}, 32'h0);
    check("rst_done", {31'b0, done}, 32'h0);
    check("rst_hi", hi, 32'h0);
    check("rst_lo", lo, 32'h0);
    check("rst_ovf", {31'b0, overflow}, 32'h0);

    for (int i = 0; i < 10; i++) run_vec($sformatf("v%0d", i), vecs[i]);

    // start pulses while busy must be ignored: single done, original operands used.
    @(negedge clk);
    issue(2'b01, 32'd3, 32'd4);
    @(posedge clk);
    #1 start = 1'b0;
    dones = 0; lat = 0;
    for (int c = 1; c <= 45; c++) begin
      @(posedge clk);
      #1;
      if (done) begin
        dones++;
        lat = c;
      end
      if (c == 5 || c == 20) issue(2'b11, 32'd1, 32'd1);
      else start = 1'b0;
    end
    check("ign_dones", dones, 1);
    check("ign_lat", lat, 34);
    check("ign_hi", hi, 32'h0);
    check("ign_lo", lo, 32'd12);
    prev_hi = 32'h0; prev_lo = 32'd12;

    // start raised in the done cycle is accepted; previous result holds meanwhile.
    @(negedge clk);
    issue(2'b00, 32'd9, 32'd9);
    wait_done(lat, bad);
    check("b2b_a_lat", lat, 34);
    check("b2b_a_lo", lo, 32'd81);
    prev_hi = 32'h0; prev_lo = 32'd81;
    issue(2'b11, 32'd100, 32'd7);
    wait_done(lat, bad);
    check("b2b_b_lat", lat, 34);
    check("b2b_b_hold", bad, 0);
    check("b2b_b_hi", hi, 32'd2);
    check("b2b_b_lo", lo, 32'd14);
    prev_hi = 32'd2; prev_lo = 32'd14;

    // Reset mid-ITER of a MULT aborts: outputs clear, no done afterwards.
    @(negedge clk);
    issue(2'b00, 32'hFFFF_FFFD, 32'd5);
    @(posedge clk);
    #1 start = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    @(posedge clk);
    #1;
    check("mrst_done", {31'b0, done}, 32'h0);
    rst = 1'b0;
    check("mrst_busy", {31'b0, busy}, 32'h0);
    check("mrst_hi", hi, 32'h0);
    check("mrst_lo", lo, 32'h0);
    dones = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk);
      #1;
      if (done || busy) dones++;
    end
    check("mrst_quiet", dones, 0);
    check("mrst_hi_hold", hi, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
